hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the stall and flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding mux selects. It sequences multi-cycle data-memory accesses through a wait FSM with a timeout fault. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum WAIT cycles before fault; legal range 1..65535.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- rs1D, rs2D  in  5  source registers of the instruction in ID.
- rs1E, rs2E, rdE  in  5  source and destination registers of the instruction in EX.
- ResultSrcE  in  2  result select of the EX instruction; 2'b01 = load.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- rdM, rdW  in  5  destination register in MEM and in WB.
- regWriteM, regWriteW  in  1  register-write enable in MEM and in WB.
- memReqM  in  1  load or store present in MEM.
- memReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- FlushD, FlushE, FlushW  out  1  insert a bubble into IF/ID, ID/EX, MEM/WB.
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 10 aluResultM, 01 ResultW.
- memFault  out  1  sticky memory-timeout fault.
- stallCount  out  CNT_W  saturating count of cycles with StallF=1.

## Operation
- Forwarding is combinational and computed per operand (shown for A; B identical with rs2E):
  - rs1E!=0 && regWriteM && rs1E==rdM gives 10;
  - otherwise rs1E!=0 && regWriteW && rs1E==rdW gives 01;
  - otherwise 00.
  - MEM has priority over WB.
- Load-use stall: lwStall = ResultSrcE==2'b01 && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- Memory FSM states:
  - M_IDLE:
    - memReqM && !memReadyM goes to M_WAIT; waitCnt is set to 1.
    - Any other input combination stays in M_IDLE.
  - M_WAIT:
    - memReadyM goes to M_IDLE.
    - Otherwise, if waitCnt==MEM_TIMEOUT, go to M_FAULT.
    - Otherwise waitCnt increments.
  - M_FAULT: terminal; only RST_N leaves it.
- memStall = (M_IDLE && memReqM && !memReadyM) || (M_WAIT && !memReadyM) || M_FAULT.
- Output priority, highest first:
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; lwStall and PCSrcE are ignored that cycle.
  - Otherwise, with no memStall:
    - StallF = StallD = lwStall.
    - FlushD = PCSrcE.
    - FlushE = lwStall || PCSrcE.
    - StallE = StallM = FlushW = 0.
- lwStall and PCSrcE cannot both be true: both describe the single EX instruction.
- memFault = 1 exactly while in M_FAULT.
- stallCount increments on every cycle with StallF=1 and saturates at all-ones.

## Timing
- Reset (RST_N low, asynchronous):
  - state = M_IDLE, waitCnt = 0, stallCount = 0, memFault = 0.
  - All stall and flush outputs = 0.
  - Forward outputs follow the combinational equations.
- Stall, flush and forward outputs are combinational from the inputs and current state, valid in the same cycle; there is no added latency.
- Memory handshake, for an access entering MEM in cycle t:
  - memReadyM=1 in cycle t: no stall.
  - First memReadyM=1 in cycle t+k: the stall spans cycles t..t+k-1 (k cycles). In cycle t+k, MEM/WB captures the data and the pipeline advances.
- Timeout, for a request first held in M_IDLE at cycle t with memReadyM low throughout:
  - waitCnt reaches MEM_TIMEOUT at cycle t+MEM_TIMEOUT.
  - The state is M_FAULT and memFault=1 from cycle t+MEM_TIMEOUT+1.
  - memReadyM in the same cycle as the timeout check wins: the FSM returns to M_IDLE.
- Reset asserted mid-WAIT returns to M_IDLE immediately; the pending access is abandoned.

## Structure
- Shared package pipe_pkg: FSM state enum (M_IDLE, M_WAIT, M_FAULT), forward select constants (FWD_REG, FWD_MEM, FWD_WB), RESULT_LOAD=2'b01.
- One natural sub-module, fwd_sel: the purely combinational forward select for one operand, instantiated twice.

## Test plan
- Forwarding: rdM=5/regWriteM=1 and rdW=5/regWriteW=1 with rs1E=5 → ForwardAE=10. rs2E=0 with rdM=0 → ForwardBE=00.
- Load-use: ResultSrcE=01, rdE=3, rs2D=3, no memReqM → StallF=StallD=FlushE=1 for one cycle; stallCount goes 0→1.
- Branch: PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- Memory wait: memReqM=1 with memReadyM low for 3 cycles, then high → StallF..M=1 and FlushW=1 for exactly 3 cycles, all 0 on the 4th.
- Timeout with MEM_TIMEOUT=4: memReadyM held low → memFault=1 from cycle 5 and stalls persist. Asserting RST_N low clears memFault, state and stallCount asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage core hazard controller.
//   - mem_state_e   : data-memory wait FSM states
//   - FWD_*         : EX-stage operand forward selects
//   - RESULT_LOAD   : ResultSrcE encoding of a load
//   - reg_hit()     : "source register is nonzero and matches this dest"
package pipe_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 16;   // holds any MEM_TIMEOUT up to 65535

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WAIT  = 2'd1,
        M_FAULT = 2'd2
    } mem_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_hit(input reg_idx_t src, input reg_idx_t dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: combinational forward select for one EX-stage operand.
// Ports:
//   rsE_i        source register of the operand in EX
//   rdM_i/rdW_i  destination registers in MEM / WB
//   regWriteM_i/regWriteW_i  write enables in MEM / WB
//   fwd_o        FWD_MEM (10), FWD_WB (01) or FWD_REG (00)
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rsE_i,
    input  logic [REG_W-1:0] rdM_i,
    input  logic [REG_W-1:0] rdW_i,
    input  logic             regWriteM_i,
    input  logic             regWriteW_i,
    output logic [1:0]       fwd_o
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_o = FWD_REG;
        if (regWriteM_i && reg_hit(rsE_i, rdM_i)) begin
            fwd_o = FWD_MEM;
        end else if (regWriteW_i && reg_hit(rsE_i, rdW_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Drives stall/flush enables of the pipeline registers, the EX forward
// selects, sequences multi-cycle data-memory accesses (with a sticky
// timeout fault) and counts stalled fetch cycles.
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   rs1D, rs2D                 ID source registers
//   rs1E, rs2E, rdE, ResultSrcE, PCSrcE   EX instruction info
//   rdM, rdW, regWriteM, regWriteW        MEM/WB writeback info
//   memReqM, memReadyM         data-memory request / completion in MEM
//   StallF/D/E/M, FlushD/E/W   pipeline register controls
//   ForwardAE, ForwardBE       EX operand forward selects
//   memFault                   sticky memory-timeout fault
//   stallCount                 saturating count of StallF cycles
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             memFault,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic lw_stall;
    logic mem_stall;

    // ---------------- forwarding ----------------
    fwd_sel u_fwd_a (
        .rsE_i       (rs1E),
        .rdM_i       (rdM),
        .rdW_i       (rdW),
        .regWriteM_i (regWriteM),
        .regWriteW_i (regWriteW),
        .fwd_o       (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rsE_i       (rs2E),
        .rdM_i       (rdM),
        .rdW_i       (rdW),
        .regWriteM_i (regWriteM),
        .regWriteW_i (regWriteW),
        .fwd_o       (ForwardBE)
    );

    // ---------------- load-use ----------------
    assign lw_stall = (ResultSrcE == RESULT_LOAD) && (rdE != '0) &&
                      ((rdE == rs1D) || (rdE == rs2D));

    // ---------------- memory wait FSM ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= M_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            M_IDLE: begin
                if (memReqM && !memReadyM) begin
                    state_d    = M_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            M_WAIT: begin
                // A late ready still wins over the timeout check.
                if (memReadyM) begin
                    state_d = M_IDLE;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    state_d = M_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            M_FAULT: begin
                state_d = M_FAULT;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

    // Stall in the request cycle itself and every WAIT cycle until ready;
    // the ready cycle lets MEM/WB capture the data.
    assign mem_stall = ((state_q == M_IDLE) && memReqM && !memReadyM) ||
                       ((state_q == M_WAIT) && !memReadyM) ||
                       (state_q == M_FAULT);

    assign memFault = (state_q == M_FAULT);

    // ---------------- stall / flush outputs ----------------
    // Held low while reset is asserted so the pipeline is not frozen by
    // stale memory/request inputs during reset.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (RST_N) begin
            if (mem_stall) begin
                // Whole pipe frozen; WB gets a bubble since MEM has no data.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end
        end
    end

    // ---------------- stall-cycle counter ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;

endmodule
